fpu_pipe_issue: RTL and testbench

Parametrised issue/completion controller around the fixed-latency `fpu_pipe` core. It adds a valid/ready handshake on both sides, carries a destination tag alongside each operation, and buffers results in a FIFO so the downstream writeback stage can stall. The `fpu_pipe` core itself cannot stall, so a credit counter guarantees that every issued operation has a FIFO slot waiting for it. It sits between the decode/issue stage and the FP register-file writeback.

---
 rtl/fpu_pipe_pkg.sv | 111 +++++++++++
 rtl/fpu_pipe.sv | 54 +++++
 rtl/fpu_result_fifo.sv | 77 +++++++
 rtl/fpu_pipe_issue.sv | 134 +++++++++++++
 tb/tb_fpu_pipe_issue.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_pipe_pkg
// Brief   : Shared constants and arithmetic helpers for the fpu_pipe core and
//           its issue/completion controller.
// Revision: 1.0 - initial release
// ============================================================================
package fpu_pipe_pkg;

   // Default core latency (operand capture to result)
   localparam int FPU_PIPE_LATENCY = 4;

   // Operation select codes
   localparam logic [4:0] FUNCT5_FADD = 5'b00000;
   localparam logic [4:0] FUNCT5_FSUB = 5'b00001;
   localparam logic [4:0] FUNCT5_FMUL = 5'b00010;

   // Rounding modes honoured by the core; other encodings round to nearest
   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;

   // Pointer width that stays legal for a single-entry buffer
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Single-precision add for normal operands; exponent field 0 is treated as zero.
   // Bits shifted out beyond the three guard positions are dropped.
   function automatic logic [31:0] fp_add(input logic [31:0] a_in,
                                          input logic [31:0] b_in,
                                          input logic        rnd);
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  d;
      logic [26:0] ma;
      logic [26:0] mb;
      logic [27:0] s;
      logic [7:0]  e;
      logic        up;
      logic [23:0] mant_r;
      // a always holds the larger magnitude, so its sign wins
      if (a_in[30:0] >= b_in[30:0]) begin
         a = a_in;
         b = b_in;
      end else begin
         a = b_in;
         b = a_in;
      end
      if (b[30:23] == 8'd0) return a;
      d  = a[30:23] - b[30:23];
      ma = {1'b1, a[22:0], 3'b000};
      mb = {1'b1, b[22:0], 3'b000};
      mb = (d > 8'd26) ? 27'd0 : (mb >> d);
      if (a[31] == b[31]) s = {1'b0, ma} + {1'b0, mb};
      else                s = {1'b0, ma} - {1'b0, mb};
      if (s == 28'd0) return 32'd0;
      e = a[30:23];
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 8'd1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!s[26]) begin
               s = s << 1;
               e = e - 8'd1;
            end
         end
      end
      up     = rnd && s[2] && (s[1] || s[0] || s[3]);
      mant_r = {1'b0, s[25:3]} + {23'd0, up};
      if (mant_r[23]) e = e + 8'd1;
      return {a[31], e, mant_r[22:0]};
   endfunction

   // Single-precision multiply for normal operands; underflow flushes to zero,
   // overflow saturates to infinity.
   function automatic logic [31:0] fp_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        rnd);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] mant;
      logic        g;
      logic        st;
      logic        up;
      logic [23:0] mant_r;
      logic        sgn;
      sgn = a[31] ^ b[31];
      if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return {sgn, 31'd0};
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (p[47]) begin
         mant = p[46:24];
         g    = p[23];
         st   = |p[22:0];
         e    = e + 10'd1;
      end else begin
         mant = p[45:23];
         g    = p[22];
         st   = |p[21:0];
      end
      up     = rnd && g && (st || mant[0]);
      mant_r = {1'b0, mant} + {23'd0, up};
      if (mant_r[23]) e = e + 10'd1;
      if (e[9] || (e[7:0] == 8'd0)) return {sgn, 31'd0};
      if (e[8] || (e[7:0] == 8'hFF)) return {sgn, 8'hFF, 23'd0};
      return {sgn, e[7:0], mant_r[22:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fpu_pipe
// Brief   : Fixed-latency, non-stallable FP add/sub/mul core. The result of
//           the operands captured at a clock edge appears LATENCY cycles later.
//           Operation validity is tracked by the surrounding controller.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_pipe
   import fpu_pipe_pkg::*;
#(
   parameter int LATENCY = FPU_PIPE_LATENCY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [4:0]  funct5,
   input  logic [2:0]  rm,
   output logic [31:0] res
);

   logic [31:0]               comb_res;
   logic                      rnd;
   logic [LATENCY-1:0][31:0]  stage;

   // Evaluate the selected operation on the incoming operands
   always_comb begin
      comb_res = 32'd0;
      rnd      = (rm != RM_RTZ);
      case (funct5)
         FUNCT5_FADD: comb_res = fp_add(x, y, rnd);
         FUNCT5_FSUB: comb_res = fp_add(x, {~y[31], y[30:0]}, rnd);
         FUNCT5_FMUL: comb_res = fp_mul(x, y, rnd);
         default:     comb_res = 32'd0;
      endcase
   end

   // Delay line that sets the fixed latency; it advances every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else begin
         stage[0] <= comb_res;
         for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign res = stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fpu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fpu_result_fifo
// Brief   : Result buffer with push/pop/count and synchronous flush. Pointers
//           wrap modulo DEPTH (any DEPTH >= 2). When empty, the output keeps
//           showing the last popped entry.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_result_fifo
   import fpu_pipe_pkg::*;
#(
   parameter  int WIDTH = 37,
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [WIDTH-1:0] hold;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push = push && !flush;
   assign do_pop  = pop && (count != '0) && !flush;

   // Pointer and count bookkeeping; flush empties the buffer at the edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; entries are only read once written, so no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Remember the departing head so the output stays stable when empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         hold <= '0;
      else if (do_pop) hold <= mem[rd_ptr];
   end

   assign pop_data = (count == '0) ? hold : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fpu_pipe_issue.sv
`default_nettype none
// ============================================================================
// Module  : fpu_pipe_issue
// Brief   : Issue/completion controller around fpu_pipe. Valid/ready on both
//           sides, a tag carried alongside each op, and a credit counter that
//           reserves a result-FIFO slot for every issued op because the core
//           cannot stall.
//           Optional macro FPU_PIPE_FLUSH_EN adds a flush input that discards
//           every in-flight and buffered result.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_pipe_issue
   import fpu_pipe_pkg::*;
#(
   parameter int LATENCY = FPU_PIPE_LATENCY,
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
`ifdef FPU_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [31:0]      in_y,
   input  logic [4:0]       in_funct5,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                          do_flush;
   logic                          issue;
   logic                          pop;
   logic [CNT_W-1:0]              occ;
   logic [CNT_W-1:0]              fifo_count;
   logic [LATENCY-1:0]            sr_valid;
   logic [LATENCY-1:0][TAG_W-1:0] sr_tag;
   logic [31:0]                   core_res;
   logic [TAG_W+31:0]             fifo_out;

`ifdef FPU_PIPE_FLUSH_EN
   assign do_flush = flush;
`else
   assign do_flush = 1'b0;
`endif

   // Credit check only looks at registered occupancy, never at out_ready
   assign in_ready  = (occ < CNT_W'(DEPTH)) && !rst && !do_flush;
   assign issue     = in_valid && in_ready;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign busy      = (occ != '0);

   fpu_pipe #(
      .LATENCY (LATENCY)
   ) u_core (
      .clk    (clk),
      .rst_n  (~rst),
      .x      (in_x),
      .y      (in_y),
      .funct5 (in_funct5),
      .rm     (in_rm),
      .res    (core_res)
   );

   // Valid bits of the tracking shift register, in lockstep with the core
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_valid <= '0;
      end else if (do_flush) begin
         sr_valid <= '0;
      end else begin
         sr_valid[0] <= issue;
         for (int i = 1; i < LATENCY; i++) begin
            sr_valid[i] <= sr_valid[i-1];
         end
      end
   end

   // Tags travel alongside the valids; their value only matters when valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_tag <= '0;
      end else begin
         sr_tag[0] <= in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            sr_tag[i] <= sr_tag[i-1];
         end
      end
   end

   // Occupancy = in flight + buffered; a simultaneous issue and pop cancel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= '0;
      end else if (do_flush) begin
         occ <= '0;
      end else begin
         case ({issue, pop})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   fpu_result_fifo #(
      .WIDTH (TAG_W + 32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (do_flush),
      .push      (sr_valid[LATENCY-1]),
      .push_data ({core_res, sr_tag[LATENCY-1]}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .count     (fifo_count)
   );

   assign out_res = fifo_out[TAG_W+31:TAG_W];
   assign out_tag = fifo_out[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fpu_pipe_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_pipe_issue
// Brief   : Directed bench for fpu_pipe_issue: a table of single operations
//           with hand-computed results, plus streaming, backpressure,
//           full-boundary, mid-flight reset and (with FPU_PIPE_FLUSH_EN)
//           flush sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpu_pipe_issue;
   import fpu_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
`ifdef FPU_PIPE_FLUSH_EN
   logic        flush;
`endif
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic [31:0] in_y;
   logic [4:0]  in_funct5;
   logic [2:0]  in_rm;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [4:0]  out_tag;
   logic        busy;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      string       name;
      logic [4:0]  f;
      logic [2:0]  rm;
      logic [31:0] x;
      logic [31:0] y;
      logic [4:0]  tag;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs [10];

   fpu_pipe_issue dut (
      .clk       (clk),
      .rst       (rst),
`ifdef FPU_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_funct5 (in_funct5),
      .in_rm     (in_rm),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, measure latency to out_valid, check head, pop it
   task automatic run_vec(input vec_t v);
      int lat;
      in_x      = v.x;
      in_y      = v.y;
      in_funct5 = v.f;
      in_rm     = v.rm;
      in_tag    = v.tag;
      in_valid  = 1'b1;
      check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({v.name, " latency"}, 32'(lat), 32'd5);
      check({v.name, " res"}, out_res, v.exp_res);
      check({v.name, " tag"}, 32'(out_tag), 32'(v.tag));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({v.name, " out_valid after pop"}, 32'(out_valid), 32'd0);
      check({v.name, " busy after pop"}, 32'(busy), 32'd0);
      check({v.name, " res held"}, out_res, v.exp_res);
   endtask

   initial begin
      int acc;
      int next_tag;
      int exp_tag;

      vecs[0] = '{"add_1_2",      FUNCT5_FADD, 3'd0, 32'h3F800000, 32'h40000000, 5'd3,  32'h40400000};
      vecs[1] = '{"mul_2_3",      FUNCT5_FMUL, 3'd0, 32'h40000000, 32'h40400000, 5'd7,  32'h40C00000};
      vecs[2] = '{"add_1p5_1p5",  FUNCT5_FADD, 3'd0, 32'h3FC00000, 32'h3FC00000, 5'd9,  32'h40400000};
      vecs[3] = '{"add_3_m1",     FUNCT5_FADD, 3'd0, 32'h40400000, 32'hBF800000, 5'd12, 32'h40000000};
      vecs[4] = '{"sub_3_1",      FUNCT5_FSUB, 3'd0, 32'h40400000, 32'h3F800000, 5'd31, 32'h40000000};
      vecs[5] = '{"mul_2_mhalf",  FUNCT5_FMUL, 3'd0, 32'h40000000, 32'hBF000000, 5'd0,  32'hBF800000};
      vecs[6] = '{"add_1_0",      FUNCT5_FADD, 3'd0, 32'h3F800000, 32'h00000000, 5'd17, 32'h3F800000};
      vecs[7] = '{"add_rne_up",   FUNCT5_FADD, 3'd0, 32'h3F800000, 32'h33C00000, 5'd21, 32'h3F800001};
      vecs[8] = '{"add_rtz",      FUNCT5_FADD, 3'd1, 32'h3F800000, 32'h33C00000, 5'd22, 32'h3F800000};
      vecs[9] = '{"mul_1p5_1p5",  FUNCT5_FMUL, 3'd0, 32'h3FC00000, 32'h3FC00000, 5'd30, 32'h40100000};

      rst       = 1'b1;
`ifdef FPU_PIPE_FLUSH_EN
      flush     = 1'b0;
`endif
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_funct5 = '0;
      in_rm     = '0;
      in_tag    = '0;
      out_ready = 1'b0;

      // Reset state
      tick();
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post-reset in_ready", 32'(in_ready), 32'd1);

      // Table of single operations
      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i]);
      end

      // Streaming: 16 back-to-back fmuls with out_ready held high
      out_ready = 1'b1;
      exp_tag   = 0;
      for (int c = 0; c < 26; c++) begin
         if (c < 16) begin
            in_valid  = 1'b1;
            in_funct5 = FUNCT5_FMUL;
            in_rm     = 3'd0;
            in_x      = 32'h40000000;
            in_y      = 32'h40400000;
            in_tag    = 5'(c);
            check("stream in_ready", 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         check("stream out_valid", 32'(out_valid), 32'((c >= 5) && (c < 21)));
         if (out_valid) begin
            check("stream tag", 32'(out_tag), 32'(exp_tag));
            check("stream res", out_res, 32'h40C00000);
            exp_tag++;
         end
         tick();
      end
      check("stream result count", 32'(exp_tag), 32'd16);
      out_ready = 1'b0;

      // Backpressure: fill to DEPTH with out_ready low
      in_valid  = 1'b1;
      in_funct5 = FUNCT5_FADD;
      in_x      = 32'h3F800000;
      in_y      = 32'h3F800000;
      acc       = 0;
      next_tag  = 0;
      for (int c = 0; c < 20; c++) begin
         in_tag = 5'(next_tag);
         if (in_ready) begin
            acc++;
            next_tag++;
         end
         tick();
      end
      check("bp accepted", 32'(acc), 32'd8);
      check("bp in_ready full", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      // Full: pop with an attempted issue -> issue rejected
      in_tag    = 5'(next_tag);
      out_ready = 1'b1;
      check("full head tag", 32'(out_tag), 32'd0);
      check("full issue rejected", 32'(in_ready), 32'd0);
      tick();
      // occ 7: issue plus pop keeps occ at 7
      check("ready after pop", 32'(in_ready), 32'd1);
      check("head tag 1", 32'(out_tag), 32'd1);
      in_tag = 5'(next_tag);
      next_tag++;
      tick();
      out_ready = 1'b0;
      check("ready at occ 7", 32'(in_ready), 32'd1);
      in_tag = 5'(next_tag);
      next_tag++;
      tick();
      in_valid = 1'b0;
      check("full again", 32'(in_ready), 32'd0);
      // Drain: every remaining result in order, none lost or duplicated
      out_ready = 1'b1;
      exp_tag   = 2;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) begin
            check("bp drain tag", 32'(out_tag), 32'(exp_tag));
            check("bp drain res", out_res, 32'h40000000);
            exp_tag++;
         end
         tick();
      end
      check("bp drained count", 32'(exp_tag), 32'd10);
      check("bp busy idle", 32'(busy), 32'd0);
      out_ready = 1'b0;

      // Mid-flight reset: 2 buffered, 3 in flight
      in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         in_tag = 5'(20 + c);
         tick();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("mf buffered", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_tag = 5'(22 + c);
         tick();
      end
      in_valid = 1'b0;
      check("mf busy before reset", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mf out_valid in reset", 32'(out_valid), 32'd0);
      check("mf in_ready in reset", 32'(in_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("mf in_ready", 32'(in_ready), 32'd1);
      check("mf busy", 32'(busy), 32'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         check("mf no output", 32'(out_valid), 32'd0);
         tick();
      end
      out_ready = 1'b0;

`ifdef FPU_PIPE_FLUSH_EN
      // Flush with 4 ops in flight, then a fresh op right after
      in_valid  = 1'b1;
      in_funct5 = FUNCT5_FMUL;
      in_x      = 32'h40000000;
      in_y      = 32'h40400000;
      for (int c = 0; c < 4; c++) begin
         in_tag = 5'(c);
         tick();
      end
      flush  = 1'b1;
      in_tag = 5'd29;
      check("flush in_ready", 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush out_valid", 32'(out_valid), 32'd0);
      check("flush busy", 32'(busy), 32'd0);
      run_vec(vecs[0]);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
